// File: rtl/b1_bist_ctrl.sv
// -----------------------------------------------------------------------------
// b1_bist_ctrl
//
// Built-in self-test sequencer for the b1 combinational block. A start request
// walks the eight input vectors {a,b,c} = 0..7 into the block. Each vector is
// held for SETTLE+1 cycles. The four response bits {d,e,f,g} are folded into a
// 4-bit MISR, and the final signature is compared against GOLDEN.
//
// Optional feature macro: B1_BIST_SELFCHECK_EN
//   When defined, an embedded reference model of b1 checks every captured
//   response. The first failing vector index is recorded in fail_idx.
//   When undefined, fail_idx and fail_valid stay 0.
//
// Parameters
//   SETTLE     extra wait cycles per vector before capture (0..15)
//   GOLDEN     expected final signature of a fault-free block
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   run request, honoured only in IDLE or DONE
//   abort      in   cancel a run (priority over start and capture)
//   cut_d..g   in   responses from the b1 block
//   cut_a..c   out  vector driven to the b1 block (a is the MSB)
//   busy       out  high while running or checking
//   done       out  high in DONE, sticky until the next start or abort
//   pass       out  verdict, valid while done=1
//   signature  out  MISR contents
//   fail_idx   out  first failing vector index (self-check build)
//   fail_valid out  a per-vector mismatch was seen (self-check build)
// -----------------------------------------------------------------------------
module b1_bist_ctrl #(
    parameter logic [3:0] SETTLE = 4'd0,
    parameter logic [3:0] GOLDEN = 4'h9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cut_d,
    input  logic       cut_e,
    input  logic       cut_f,
    input  logic       cut_g,
    output logic       cut_a,
    output logic       cut_b,
    output logic       cut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] signature,
    output logic [2:0] fail_idx,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One MISR step: shift s0->s1->s2->s3, with s3 fed back into s0 and s3.
    function automatic logic [3:0] misr_next(input logic [3:0] s, input logic [3:0] r);
        misr_next = {s[2] ^ s[3] ^ r[3], s[1] ^ r[2], s[0] ^ r[1], s[3] ^ r[0]};
    endfunction

`ifdef B1_BIST_SELFCHECK_EN
    // Fault-free b1 behaviour for vector p = {a,b,c}: {d,e,f,g}.
    function automatic logic [3:0] ref_resp(input logic [2:0] p);
        ref_resp = {p[0], p[2] ^ p[1], p[2] & p[1] & ~p[0], ~p[0]};
    endfunction
`endif

    state_t     state_r, state_s;
    logic [2:0] pat_r, pat_s;
    logic [3:0] wait_r, wait_s;
    logic [3:0] misr_r, misr_s;
    logic       pass_r, pass_s;
    logic       done_r, done_s;
    logic       busy_r, busy_s;
    logic [2:0] vec_r, vec_s;
    logic [2:0] fidx_r, fidx_s;
    logic       fvalid_r, fvalid_s;
    logic [3:0] resp_s;
    logic       mism_s;

    assign resp_s = {cut_d, cut_e, cut_f, cut_g};

`ifdef B1_BIST_SELFCHECK_EN
    assign mism_s = (resp_s != ref_resp(pat_r));
`else
    assign mism_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath logic; every register holds unless changed.
    always_comb begin
        state_s  = state_r;
        pat_s    = pat_r;
        wait_s   = wait_r;
        misr_s   = misr_r;
        pass_s   = pass_r;
        done_s   = done_r;
        busy_s   = busy_r;
        vec_s    = vec_r;
        fidx_s   = fidx_r;
        fvalid_s = fvalid_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort && (state_r == ST_DONE)) begin
                    // Abort also clears a sticky verdict.
                    state_s = ST_IDLE;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end else if (start) begin
                    state_s  = ST_RUN;
                    pat_s    = 3'd0;
                    wait_s   = SETTLE;
                    misr_s   = 4'h0;
                    fidx_s   = 3'd0;
                    fvalid_s = 1'b0;
                    done_s   = 1'b0;
                    pass_s   = 1'b0;
                    busy_s   = 1'b1;
                    vec_s    = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Partial signature is kept for debug.
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                    vec_s   = 3'd0;
                end else if (wait_r != 4'd0) begin
                    wait_s = wait_r - 4'd1;
                end else begin
                    misr_s = misr_next(misr_r, resp_s);
                    if (mism_s && !fvalid_r) begin
                        fvalid_s = 1'b1;
                        fidx_s   = pat_r;
                    end else begin
                        fvalid_s = fvalid_r;
                    end
                    pat_s  = pat_r + 3'd1;
                    wait_s = SETTLE;
                    if (pat_r == 3'd7) begin
                        // Pattern wraps to 0; it is not applied again.
                        state_s = ST_CHECK;
                        vec_s   = 3'd0;
                    end else begin
                        vec_s = pat_r + 3'd1;
                    end
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                    vec_s   = 3'd0;
                end else begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (misr_r == GOLDEN) && !fvalid_r;
                    vec_s   = 3'd0;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                done_s   = 1'b0;
                pass_s   = 1'b0;
                vec_s    = 3'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_r    <= 3'd0;
            wait_r   <= 4'd0;
            misr_r   <= 4'h0;
            pass_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            vec_r    <= 3'd0;
            fidx_r   <= 3'd0;
            fvalid_r <= 1'b0;
        end else begin
            pat_r    <= pat_s;
            wait_r   <= wait_s;
            misr_r   <= misr_s;
            pass_r   <= pass_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            vec_r    <= vec_s;
            fidx_r   <= fidx_s;
            fvalid_r <= fvalid_s;
        end
    end

    assign cut_a      = vec_r[2];
    assign cut_b      = vec_r[1];
    assign cut_c      = vec_r[0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign signature  = misr_r;
    assign fail_idx   = fidx_r;
    assign fail_valid = fvalid_r;

endmodule

// File: tb/tb_b1_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_b1_bist_ctrl
//
// Bench for b1_bist_ctrl. Two controllers are instantiated, with SETTLE=0 and
// SETTLE=3. Each drives a behavioural b1 model that can carry stuck-at faults.
// Expected results for each run are queued when the run is started. A monitor
// pops an entry on every rising edge of done and compares the signature,
// verdict, fail info, busy length, and the per-cycle vector sequence.
// -----------------------------------------------------------------------------
module tb_b1_bist_ctrl;

    typedef struct {
        logic [3:0] sig;
        logic       pass;
        logic       fv;
        logic [2:0] fi;
    } exp_t;

    localparam logic [3:0] GOOD_TAB [8] = '{4'h1, 4'h8, 4'h5, 4'hC, 4'h5, 4'hC, 4'h3, 4'h8};

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [3:0] sa0;
    logic [3:0] sa1;

    wire [1:0] ca, cb, cc, cd, ce, cf, cg;
    wire [1:0] busy_v, done_v, pass_v, fv_v;
    wire [3:0] sig_v [2];
    wire [2:0] fi_v  [2];

    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] pbusy;
    logic [1:0] pdone;
    int   blen [2];
    int   verr [2];

    always #5 clock = ~clock;

    // b1 response table with stuck-at-0 (z) and stuck-at-1 (o) masks.
    function automatic logic [3:0] cut_resp(input logic [2:0] v, input logic [3:0] z, input logic [3:0] o);
        return (GOOD_TAB[v] & ~z) | o;
    endfunction

    assign {cd[0], ce[0], cf[0], cg[0]} = cut_resp({ca[0], cb[0], cc[0]}, sa0, sa1);
    assign {cd[1], ce[1], cf[1], cg[1]} = cut_resp({ca[1], cb[1], cc[1]}, sa0, sa1);

    b1_bist_ctrl #(.SETTLE(4'd0), .GOLDEN(4'h9)) u_s0 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]),
        .cut_d(cd[0]), .cut_e(ce[0]), .cut_f(cf[0]), .cut_g(cg[0]),
        .cut_a(ca[0]), .cut_b(cb[0]), .cut_c(cc[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .signature(sig_v[0]), .fail_idx(fi_v[0]), .fail_valid(fv_v[0])
    );

    b1_bist_ctrl #(.SETTLE(4'd3), .GOLDEN(4'h9)) u_s3 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]),
        .cut_d(cd[1]), .cut_e(ce[1]), .cut_f(cf[1]), .cut_g(cg[1]),
        .cut_a(ca[1]), .cut_b(cb[1]), .cut_c(cc[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .fail_idx(fi_v[1]), .fail_valid(fv_v[1])
    );

    function automatic int settle_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Signature after the first n responses: rotate left, feed s3 into bit 3, add r.
    function automatic logic [3:0] model_sig(input logic [3:0] z, input logic [3:0] o, input int n);
        logic [3:0] s = 4'h0;
        for (int p = 0; p < n; p++) begin
            s = (((s << 1) | (s >> 3)) & 4'hF) ^ (s[3] ? 4'h8 : 4'h0) ^ cut_resp(3'(p), z, o);
        end
        return s;
    endfunction

    function automatic exp_t model_run(input logic [3:0] z, input logic [3:0] o);
        exp_t e;
        logic fv = 1'b0;
        logic [2:0] fi = 3'd0;
        for (int p = 0; p < 8; p++) begin
            if (!fv && (cut_resp(3'(p), z, o) != GOOD_TAB[p])) begin
                fv = 1'b1;
                fi = 3'(p);
            end
        end
        e.sig = model_sig(z, o, 8);
`ifdef B1_BIST_SELFCHECK_EN
        e.fv   = fv;
        e.fi   = fi;
        e.pass = (e.sig == 4'h9) && !fv;
`else
        e.fv   = 1'b0;
        e.fi   = 3'd0;
        e.pass = (e.sig == 4'h9);
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor step for one controller, sampled on the falling edge.
    task automatic mon_step(input int i);
        int s;
        exp_t e;
        logic [2:0] want;
        s = settle_of(i);
        if (!reset_n) begin
            pbusy[i] = 1'b0;
            pdone[i] = 1'b0;
            return;
        end
        if (busy_v[i]) begin
            if (!pbusy[i]) begin
                blen[i] = 0;
                verr[i] = 0;
            end
            want = (blen[i] < 8 * (s + 1)) ? 3'(blen[i] / (s + 1)) : 3'd0;
            if ({ca[i], cb[i], cc[i]} != want) verr[i]++;
            blen[i]++;
        end
        if (done_v[i] && !pdone[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                check($sformatf("done_unexpected[%0d]", i), 32'(done_v[i]), 32'd0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("signature[%0d]", i), 32'(sig_v[i]), 32'(e.sig));
                check($sformatf("pass[%0d]", i), 32'(pass_v[i]), 32'(e.pass));
                check($sformatf("fail_valid[%0d]", i), 32'(fv_v[i]), 32'(e.fv));
                check($sformatf("fail_idx[%0d]", i), 32'(fi_v[i]), 32'(e.fi));
                check($sformatf("busy_len[%0d]", i), 32'(blen[i]), 32'(8 * (s + 1) + 1));
                check($sformatf("vec_seq_errs[%0d]", i), 32'(verr[i]), 32'd0);
                check($sformatf("cut_in_done[%0d]", i), 32'({ca[i], cb[i], cc[i]}), 32'd0);
            end
        end
        pbusy[i] = busy_v[i];
        pdone[i] = done_v[i];
    endtask

    initial begin
        pbusy = 2'b00;
        pdone = 2'b00;
        blen  = '{0, 0};
        verr  = '{0, 0};
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic check_zero_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[%0d]", name, i),
                  32'({busy_v[i], done_v[i], pass_v[i], ca[i], cb[i], cc[i], sig_v[i], fi_v[i], fv_v[i]}),
                  32'd0);
        end
    endtask

    // Waits for done, bounded; checks the start-to-done latency.
    task automatic wait_done(input int i);
        int lat = 0;
        while (!done_v[i] && lat < 200) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        check($sformatf("done_latency[%0d]", i), 32'(lat), 32'(8 * (settle_of(i) + 1) + 1));
    endtask

    task automatic do_run(input int i, input logic [3:0] z, input logic [3:0] o);
        sa0 = z;
        sa1 = o;
        push_exp(i, model_run(z, o));
        start_v[i] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_v[i] = 1'b0;
        wait_done(i);
        @(negedge clock);
    endtask

    task automatic do_abort(input int i);
        int n = 0;
        sa0 = 4'h0;
        sa1 = 4'h0;
        start_v[i] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_v[i] = 1'b0;
        while (({ca[i], cb[i], cc[i]} != 3'd4) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("reach_vec4[%0d]", i), 32'({ca[i], cb[i], cc[i]}), 32'd4);
        repeat ($urandom_range(0, settle_of(i))) @(negedge clock);
        abort_v[i] = 1'b1;
        @(posedge clock);
        #1;
        check($sformatf("abort_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
        check($sformatf("abort_done[%0d]", i), 32'(done_v[i]), 32'd0);
        check($sformatf("abort_pass[%0d]", i), 32'(pass_v[i]), 32'd0);
        check($sformatf("abort_partial_sig[%0d]", i), 32'(sig_v[i]), 32'(model_sig(4'h0, 4'h0, 4)));
        @(negedge clock);
        abort_v[i] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] z;
        logic [3:0] o;
        int i;
        reset_n = 1'b0;
        start_v = 2'b00;
        abort_v = 2'b00;
        sa0     = 4'h0;
        sa1     = 4'h0;
        #1;
        check_zero_outputs("reset_state");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Fault-free, SETTLE=0.
        do_run(0, 4'h0, 4'h0);
        check("directed_good_sig", 32'(sig_v[0]), 32'h9);
        check("directed_good_pass", 32'(pass_v[0]), 32'd1);

        // cut_f stuck at 0.
        do_run(0, 4'b0010, 4'h0);
        check("directed_f_sa0_sig", 32'(sig_v[0]), 32'hD);
        check("directed_f_sa0_pass", 32'(pass_v[0]), 32'd0);

        // Fault-free, SETTLE=3.
        do_run(1, 4'h0, 4'h0);
        check("directed_settle3_sig", 32'(sig_v[1]), 32'h9);

        // Abort during vector 4, then a clean run on each controller.
        do_abort(0);
        do_run(0, 4'h0, 4'h0);
        do_abort(1);
        do_run(1, 4'h0, 4'h0);

        // Asynchronous reset in the middle of a run on both controllers.
        start_v = 2'b11;
        @(posedge clock);
        @(negedge clock);
        start_v = 2'b00;
        repeat ($urandom_range(2, 6)) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("reset_midrun");
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        do_run(0, 4'h0, 4'h0);
        do_run(1, 4'h0, 4'h0);

        // start held high: no restart while busy, re-run right after DONE.
        sa0 = 4'h0;
        sa1 = 4'h0;
        push_exp(0, model_run(4'h0, 4'h0));
        push_exp(0, model_run(4'h0, 4'h0));
        start_v[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wait_done(0);
        @(posedge clock);
        #1;
        check("held_start_done_drop", 32'(done_v[0]), 32'd0);
        check("held_start_rerun_busy", 32'(busy_v[0]), 32'd1);
        @(negedge clock);
        start_v[0] = 1'b0;
        wait_done(0);
        @(negedge clock);

        // Randomized fault patterns on random controllers.
        repeat (16) begin
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                z = 4'h0;
                o = 4'h0;
            end else begin
                z = 4'($urandom);
                o = 4'($urandom) & ~z;
            end
            do_run(i, z, o);
        end

        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
